// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch/decode types, NOP encoding and instruction field positions
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // sll r0,r0,0 doubles as the pipeline bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// rtl/fetch_stage_ifid_reg.sv - IF/ID pipeline register with load/hold/flush and field slicing
module ifid_reg
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [31:0]       instr_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        func,
  output logic [15:0]       imm,
  output logic [25:0]       target
);

  logic [31:0] instr;

  // flush beats load so a bubble always carries an all-zero word
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end
  end

  assign op     = instr[OP_MSB:OP_LSB];
  assign rs     = instr[RS_MSB:RS_LSB];
  assign rt     = instr[RT_MSB:RT_LSB];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
  assign func   = instr[FUNC_MSB:FUNC_LSB];
  assign imm    = instr[IMM_MSB:IMM_LSB];
  assign target = instr[TARGET_MSB:TARGET_LSB];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM, PC, redirect/stall handling feeding the IF/ID register
module fetch_stage
  import mips_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [5:0]        id_op,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [4:0]        id_shamt,
  output logic [5:0]        id_func,
  output logic [15:0]       id_imm,
  output logic [25:0]       id_target
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_pc;
  logic [31:0]       buf_instr;
  logic [ADDR_W-1:0] buf_pc;
  logic [ADDR_W-1:0] rpc;
  logic              load;
  logic              flush;
  logic [31:0]       ifid_instr;
  logic [ADDR_W-1:0] ifid_pc;

  assign rpc       = redirect_pc & ~ADDR_W'(3);
  assign imem_req  = !reset && (state != HOLD);
  assign imem_addr = pc;

  always_comb begin
    load       = 1'b0;
    flush      = 1'b0;
    ifid_instr = imem_rdata;
    ifid_pc    = pc;
    case (state)
      FETCH: begin
        if (redirect)                flush = 1'b1;
        else if (imem_ack && !stall) load  = 1'b1;
        else if (!stall)             flush = 1'b1;
      end
      HOLD: begin
        if (redirect) flush = 1'b1;
        else if (!stall) begin
          load       = 1'b1;
          ifid_instr = buf_instr;
          ifid_pc    = buf_pc;
        end
      end
      default: flush = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      pend_pc   <= '0;
      buf_instr <= NOP_INSTR;
      buf_pc    <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            // without an ack the request is still outstanding, so pc must stay put
            if (imem_ack) pc <= rpc;
            else begin
              pend_pc <= rpc;
              state   <= DISCARD;
            end
          end else if (imem_ack) begin
            pc <= pc + ADDR_W'(4);
            if (stall) begin
              buf_instr <= imem_rdata;
              buf_pc    <= pc;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= rpc;
            state <= FETCH;
          end else if (!stall) begin
            state <= FETCH;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            pc    <= redirect ? rpc : pend_pc;
            state <= FETCH;
          end else if (redirect) begin
            pend_pc <= rpc;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  ifid_reg #(.ADDR_W(ADDR_W)) u_ifid (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .flush    (flush),
    .instr_in (ifid_instr),
    .pc_in    (ifid_pc),
    .valid    (id_valid),
    .pc       (id_pc),
    .op       (id_op),
    .rs       (id_rs),
    .rt       (id_rt),
    .rd       (id_rd),
    .shamt    (id_shamt),
    .func     (id_func),
    .imm      (id_imm),
    .target   (id_target)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and random stimulus for fetch_stage against a transaction-level model
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        imem_req, w_req;
  logic [31:0] imem_addr, w_addr;
  logic        id_valid, w_valid;
  logic [31:0] id_pc, w_pc;
  logic [5:0]  id_op, id_func, w_op, w_func;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt, w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] id_imm, w_imm;
  logic [25:0] id_target, w_target;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // transaction-level model: flags rather than a state encoding
  logic [31:0] m_pc, m_pend_pc, m_buf, m_buf_pc, m_instr, m_idpc;
  bit          m_valid, m_buf_full, m_discarding;
  bit          chk_w = 1'b0;
  logic [31:0] w_exp;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_pc(id_pc), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_func(id_func), .id_imm(id_imm), .id_target(id_target)
  );

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(w_valid),
    .id_pc(w_pc), .id_op(w_op), .id_rs(w_rs), .id_rt(w_rt), .id_rd(w_rd),
    .id_shamt(w_shamt), .id_func(w_func), .id_imm(w_imm), .id_target(w_target)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h8) return 32'h0085_1020;
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bubble();
    m_valid = 1'b0; m_instr = 32'h0; m_idpc = 32'h0;
  endtask

  task automatic model_update(input bit r, input bit a, input bit s, input bit rd,
                              input logic [31:0] rp, input logic [31:0] data);
    logic [31:0] rpa;
    rpa = {rp[31:2], 2'b00};
    if (r) begin
      m_pc = 32'h0; m_buf_full = 1'b0; m_discarding = 1'b0; bubble();
    end else if (m_buf_full) begin
      if (rd) begin
        bubble(); m_buf_full = 1'b0; m_pc = rpa;
      end else if (!s) begin
        m_valid = 1'b1; m_instr = m_buf; m_idpc = m_buf_pc; m_buf_full = 1'b0;
      end
    end else if (m_discarding) begin
      bubble();
      if (a) begin
        m_pc = rd ? rpa : m_pend_pc; m_discarding = 1'b0;
      end else if (rd) m_pend_pc = rpa;
    end else if (rd) begin
      bubble();
      if (a) m_pc = rpa;
      else begin
        m_discarding = 1'b1; m_pend_pc = rpa;
      end
    end else if (a) begin
      if (s) begin
        m_buf = data; m_buf_pc = m_pc; m_buf_full = 1'b1;
      end else begin
        m_valid = 1'b1; m_instr = data; m_idpc = m_pc;
      end
      m_pc = m_pc + 32'd4;
    end else if (!s) bubble();
  endtask

  task automatic step(input bit r, input bit a, input bit s, input bit rd,
                      input logic [31:0] rp);
    logic [31:0] data;
    reset = r; imem_ack = a; stall = s; redirect = rd; redirect_pc = rp;
    data = mem(m_pc);
    imem_rdata = data;
    #1;
    check("imem_req", {31'b0, imem_req}, {31'b0, (!r && !m_buf_full)});
    if (!r && !m_buf_full) check("imem_addr", imem_addr, m_pc);
    if (chk_w) begin
      check("wrap_req", {31'b0, w_req}, 32'd1);
      check("wrap_addr", w_addr, w_exp);
      w_exp = w_exp + 32'd4;
    end
    @(posedge clk);
    model_update(r, a, s, rd, rp, data);
    #1;
    check("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
    if (m_valid || r) check("id_pc", id_pc, m_idpc);
    check("id_op", 32'(id_op), m_instr >> 26);
    check("id_rs", 32'(id_rs), (m_instr >> 21) & 32'h1F);
    check("id_rt", 32'(id_rt), (m_instr >> 16) & 32'h1F);
    check("id_rd", 32'(id_rd), (m_instr >> 11) & 32'h1F);
    check("id_shamt", 32'(id_shamt), (m_instr >> 6) & 32'h1F);
    check("id_func", 32'(id_func), m_instr & 32'h3F);
    check("id_imm", 32'(id_imm), m_instr & 32'hFFFF);
    check("id_target", 32'(id_target), m_instr & 32'h03FF_FFFF);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; imem_rdata = 32'h0;
    m_pc = 32'h0; m_pend_pc = 32'h0; m_buf = 32'h0; m_buf_pc = 32'h0;
    m_instr = 32'h0; m_idpc = 32'h0; m_valid = 1'b0; m_buf_full = 1'b0;
    m_discarding = 1'b0; w_exp = 32'h0;
    @(posedge clk); #1;

    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    // streaming with ack every cycle; the word at 0x8 is add r2,r4,r5
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("dir_op", 32'(id_op), 32'h0);
    check("dir_func", 32'(id_func), 32'h20);
    check("dir_rd", 32'(id_rd), 32'h2);
    check("dir_pc", id_pc, 32'h8);
    step(0, 1, 0, 0, 0);

    // ack under stall, hold three cycles, release
    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // withheld ack then redirect: outstanding data must be discarded
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h100);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_valid", {31'b0, id_valid}, 32'h0);
    step(0, 1, 0, 0, 0);

    // redirect with stall in HOLD, unaligned target
    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 32'h103);
    check("hold_redir_addr", imem_addr, 32'h100);
    check("hold_redir_valid", {31'b0, id_valid}, 32'h0);
    step(0, 1, 0, 0, 0);

    // reset while discarding
    step(0, 0, 0, 1, 32'h200);
    step(1, 0, 0, 0, 0);
    check("rst_disc_addr", imem_addr, 32'h0);
    check("rst_disc_valid", {31'b0, id_valid}, 32'h0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 8),
           $urandom);
    end

    // PC wrap on the second instance
    step(1, 0, 0, 0, 0);
    w_exp = 32'hFFFF_FFF8;
    chk_w = 1'b1;
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk_w = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage and IF/ID pipeline register. It produces the op/func and other decoded instruction fields that the controller consumes.
- Owns the PC and talks to instruction memory over a req/ack handshake.
- Accepts stall and redirect (branch/jump) from downstream.
- Presents one registered instruction per cycle, or a NOP bubble, to the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC / instruction memory address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset reset, synchronous, active-high
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  ADDR_W  word-aligned fetch address, stable while imem_req=1 and no ack
imem_ack  in  1  data valid this cycle; may assert in the same cycle as req, or later
imem_rdata  in  32  instruction word, sampled only when imem_ack=1
stall  in  1  decode cannot accept; IF/ID must hold
redirect  in  1  branch/jump taken; flush and refetch
redirect_pc  in  ADDR_W  new PC; bits [1:0] ignored (forced 00)
id_valid  out  1  IF/ID holds a real instruction
id_pc  out  ADDR_W  PC of the instruction in IF/ID
id_op  out  6  instr[31:26]
id_rs  out  5  instr[25:21]
id_rt  out  5  instr[20:16]
id_rd  out  5  instr[15:11]
id_shamt  out  5  instr[10:6]
id_func  out  6  instr[5:0]
id_imm  out  16  instr[15:0]
id_target  out  26  instr[25:0]

Behaviour:
- Reset (synchronous; priority over everything, including mid-fetch):
  - pc=RESET_PC, state=FETCH, imem_req=0 during the reset cycle.
  - id_valid=0, IF/ID instruction=32'h0000_0000, id_pc=0.
- Bubble encoding: whenever id_valid=0, the IF/ID instruction is 32'h0000_0000 (sll r0,r0,0). All id_* fields are therefore 0.
- FSM states: FETCH, HOLD, DISCARD.
- FETCH: imem_req=1, imem_addr=pc.
  - redirect & ack: drop the data; pc<=redirect_pc; id_valid<=0; stay in FETCH.
  - redirect & !ack: pend_pc<=redirect_pc; id_valid<=0; go to DISCARD. The address stays stable because the request is still outstanding.
  - ack & !stall: IF/ID<=imem_rdata; id_pc<=pc; id_valid<=1; pc<=pc+4.
  - ack & stall: buf<=imem_rdata; buf_pc<=pc; pc<=pc+4; IF/ID holds; go to HOLD.
  - !ack & !stall: IF/ID<=bubble.
  - !ack & stall: IF/ID holds.
- HOLD: imem_req=0.
  - redirect: id_valid<=0; buf dropped; pc<=redirect_pc; go to FETCH.
  - !stall: IF/ID<=buf; id_pc<=buf_pc; id_valid<=1; go to FETCH.
  - stall: hold.
- DISCARD: imem_req=1, imem_addr=old pc (unchanged). IF/ID stays bubble.
  - Another redirect overwrites pend_pc (last one wins).
  - On ack: data dropped; pc<=pend_pc (or redirect_pc if redirect is asserted in the same cycle); go to FETCH.
- Priority: reset > redirect > stall > normal advance.
- Arithmetic: pc+4 is modulo 2^ADDR_W. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Throughput: one instruction per cycle when ack is combinational in the same cycle and stall=0.
- Latency: instruction visible on id_* the cycle after ack.

Decomposition:
- mips_pkg:
  - FSM state enum (FETCH/HOLD/DISCARD).
  - NOP_INSTR=32'h0.
  - Field bit-position constants (OP_MSB/LSB, RS, RT, RD, SHAMT, FUNC, IMM, TARGET).
- One sub-module: ifid_reg. It is the pipeline register with load / hold / flush-to-NOP controls and the field slicing. fetch_stage holds the FSM, pc, pend_pc and buf.

Test Plan:
- Reset, then ack every cycle with rdata=addr-derived words, stall=0 -> imem_addr 0,4,8,...; id_valid=1 from cycle 2; id_pc lags imem_addr by one cycle; instr 0x00851020 gives id_op=0, id_func=6'h20, rd=2.
- ack with stall=1 for 3 cycles -> FSM in HOLD with imem_req=0 and IF/ID unchanged; on release the buffered word appears with the correct id_pc and fetch resumes at pc+4 with no loss or duplication.
- ack withheld 2 cycles, then redirect to 0x100 -> imem_addr stays at the old pc until ack; that data is discarded; next request addr=0x100; id_valid=0 throughout, with all fields 0.
- redirect and stall asserted together in HOLD -> flush wins; id_valid=0; next fetch addr=redirect_pc; redirect_pc=0x103 yields addr 0x100.
- RESET_PC=32'hFFFF_FFF8, ack each cycle -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- reset asserted while in DISCARD -> next cycle state=FETCH, pc=RESET_PC, id_valid=0, and pend_pc is not used.
